// File: rtl/ui_pkg.sv
// ui_pkg: menu state codes shared with the renderer, plus menu item constants.
package ui_pkg;
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_MANUAL   = 4'd1,
      ST_SOLVER   = 4'd2,
      ST_GENERATE = 4'd3
   } state_t;
   localparam logic [1:0] MENU_MANUAL   = 2'd0;
   localparam logic [1:0] MENU_SOLVER   = 2'd1;
   localparam logic [1:0] MENU_GENERATE = 2'd2;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int CNT_W           = 20
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic btn,
   output logic press
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
   logic             s1, s2, deb, deb_q;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         deb_q <= deb;
         if (s2 == deb) cnt <= '0;
         else if (cnt == LIMIT) begin
            deb <= s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
   assign press = deb & ~deb_q;
endmodule

// File: rtl/ui_menu_fsm.sv
// ui_menu_fsm: debounced buttons drive the menu FSM, cursor and engine start/busy handshake.
module ui_menu_fsm
   import ui_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int CNT_W           = 20
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       btnc,
   input  logic       btnu,
   input  logic       btnd,
   input  logic       btnl,
   input  logic       solve_done,
   input  logic       gen_done,
   output logic [3:0] state,
   output logic [1:0] cursor,
   output logic       busy,
   output logic       solve_start,
   output logic       gen_start
);
   logic [3:0] raw, prs;
   logic       sel_p, up_p, dn_p, back_p;
   state_t     st, st_n;
   logic [1:0] cur_n;
   logic       busy_n, ss_n, gs_n;
   assign raw = {btnl, btnd, btnu, btnc};
   for (genvar g = 0; g < 4; g++) begin : g_db
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
         .clk_in  (clk_in),
         .reset_in(reset_in),
         .btn     (raw[g]),
         .press   (prs[g])
      );
   end
   assign {back_p, dn_p, up_p, sel_p} = prs;
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         st          <= ST_IDLE;
         cursor      <= MENU_MANUAL;
         busy        <= 1'b0;
         solve_start <= 1'b0;
         gen_start   <= 1'b0;
      end else begin
         st          <= st_n;
         cursor      <= cur_n;
         busy        <= busy_n;
         solve_start <= ss_n;
         gen_start   <= gs_n;
      end
   end
   // A back press outranks everything, so in IDLE it swallows the other presses.
   always_comb begin
      st_n   = st;
      cur_n  = cursor;
      busy_n = busy;
      ss_n   = 1'b0;
      gs_n   = 1'b0;
      case (st)
         ST_IDLE: if (!back_p) begin
            if (sel_p) begin
               st_n   = cursor == MENU_MANUAL ? ST_MANUAL : cursor == MENU_SOLVER ? ST_SOLVER : ST_GENERATE;
               ss_n   = cursor == MENU_SOLVER;
               gs_n   = cursor == MENU_GENERATE;
               busy_n = cursor != MENU_MANUAL;
            end else if (up_p) cur_n = cursor == MENU_MANUAL ? MENU_GENERATE : cursor - 2'd1;
            else if (dn_p) cur_n = cursor == MENU_GENERATE ? MENU_MANUAL : cursor + 2'd1;
         end
         ST_MANUAL: if (back_p) st_n = ST_IDLE;
         ST_SOLVER: begin
            if (busy) busy_n = ~solve_done;
            else if (back_p) st_n = ST_IDLE;
         end
         ST_GENERATE: begin
            if (busy) busy_n = ~gen_done;
            else if (back_p) st_n = ST_IDLE;
         end
         default: st_n = ST_IDLE;
      endcase
   end
   assign state = st;
endmodule

// File: tb/tb_ui_menu_fsm.sv
// tb_ui_menu_fsm: directed menu walk with hand-computed expectations, DEBOUNCE_CYCLES=4.
module tb_ui_menu_fsm;
   logic       clk_in = 1'b0, reset_in = 1'b0;
   logic       btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0;
   logic       solve_done = 1'b0, gen_done = 1'b0;
   logic [3:0] state;
   logic [1:0] cursor;
   logic       busy, solve_start, gen_start;
   int         tests = 0, fails = 0, ss_cnt = 0, gs_cnt = 0, ss_base, gs_base;
   ui_menu_fsm #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .btnc       (btnc),
      .btnu       (btnu),
      .btnd       (btnd),
      .btnl       (btnl),
      .solve_done (solve_done),
      .gen_done   (gen_done),
      .state      (state),
      .cursor     (cursor),
      .busy       (busy),
      .solve_start(solve_start),
      .gen_start  (gen_start)
   );
   always #5 clk_in = ~clk_in;
   always @(negedge clk_in) begin
      ss_cnt <= ss_cnt + (solve_start ? 1 : 0);
      gs_cnt <= gs_cnt + (gen_start ? 1 : 0);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // m bits: 0 select, 1 up, 2 down, 3 back; state settles 8 edges after the raw edge
   task automatic tap(input logic [3:0] m);
      {btnl, btnd, btnu, btnc} = m;
      repeat (8) @(posedge clk_in);
      @(negedge clk_in);
      {btnl, btnd, btnu, btnc} = 4'b0;
      repeat (10) @(negedge clk_in);
   endtask
   initial begin
      @(negedge clk_in);
      {btnl, btnd, btnu, btnc} = 4'hf;
      #2 reset_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("rst_state", state, 0);
      check("rst_cursor", cursor, 0);
      check("rst_busy", busy, 0);
      check("rst_starts", ss_cnt + gs_cnt, 0);
      {btnl, btnd, btnu, btnc} = 4'b0;
      @(negedge clk_in);
      reset_in = 1'b0;
      repeat (12) @(negedge clk_in);
      check("post_rst_state", state, 0);
      check("post_rst_cursor", cursor, 0);
      check("post_rst_starts", ss_cnt + gs_cnt, 0);
      btnd = 1'b1;
      repeat (3) @(negedge clk_in);
      btnd = 1'b0;
      repeat (12) @(negedge clk_in);
      check("glitch_cursor", cursor, 0);
      btnd = 1'b1;
      repeat (7) @(posedge clk_in);
      @(negedge clk_in);
      check("down_early", cursor, 0);
      @(negedge clk_in);
      check("down_lat8", cursor, 1);
      repeat (12) @(negedge clk_in);
      check("down_held_once", cursor, 1);
      btnd = 1'b0;
      repeat (10) @(negedge clk_in);
      tap(4'b0010);
      check("up_to0", cursor, 0);
      tap(4'b0010);
      check("up_wrap", cursor, 2);
      tap(4'b0100);
      check("down_wrap", cursor, 0);
      tap(4'b0100);
      ss_base = ss_cnt;
      gs_base = gs_cnt;
      tap(4'b0001);
      check("solve_state", state, 2);
      check("solve_busy", busy, 1);
      check("solve_start_1cyc", ss_cnt - ss_base, 1);
      check("solve_no_gen", gs_cnt - gs_base, 0);
      tap(4'b1000);
      check("back_busy_ignored", state, 2);
      solve_done = 1'b1;
      @(negedge clk_in);
      solve_done = 1'b0;
      @(negedge clk_in);
      check("solve_done_busy", busy, 0);
      check("solve_done_state", state, 2);
      tap(4'b1000);
      check("solve_back", state, 0);
      check("cursor_kept", cursor, 1);
      tap(4'b0100);
      gs_base = gs_cnt;
      tap(4'b0001);
      check("gen_state", state, 3);
      check("gen_busy", busy, 1);
      check("gen_start_1cyc", gs_cnt - gs_base, 1);
      solve_done = 1'b1;
      @(negedge clk_in);
      solve_done = 1'b0;
      @(negedge clk_in);
      check("gen_wrong_done", busy, 1);
      // back press pulse is high between edges 7 and 8; gen_done lands on edge 8 too
      btnl = 1'b1;
      repeat (7) @(posedge clk_in);
      @(negedge clk_in);
      gen_done = 1'b1;
      @(negedge clk_in);
      gen_done = 1'b0;
      btnl = 1'b0;
      repeat (10) @(negedge clk_in);
      check("done_back_busy", busy, 0);
      check("done_back_state", state, 3);
      tap(4'b1000);
      check("gen_back", state, 0);
      solve_done = 1'b1;
      @(negedge clk_in);
      solve_done = 1'b0;
      @(negedge clk_in);
      check("idle_done_state", state, 0);
      check("idle_done_busy", busy, 0);
      tap(4'b0010);
      tap(4'b0010);
      check("back_to_c0", cursor, 0);
      tap(4'b1001);
      check("sel_back_state", state, 0);
      check("sel_back_cursor", cursor, 0);
      ss_base = ss_cnt;
      gs_base = gs_cnt;
      tap(4'b0001);
      check("manual_state", state, 1);
      check("manual_busy", busy, 0);
      check("manual_no_start", (ss_cnt - ss_base) + (gs_cnt - gs_base), 0);
      @(negedge clk_in);
      #2 reset_in = 1'b1;
      #1 check("async_rst_state", state, 0);
      @(negedge clk_in);
      reset_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("after_rst_state", state, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ui_menu_fsm.md
Name: ui_menu_fsm

Overview:
- Upstream control stage for the menu renderer; owns the 4-bit `state` code that the renderer uses to pick which ROM image is shown.
- Turns raw pushbuttons into debounced single-cycle press events.
- Runs the menu state machine (IDLE, MANUAL, SOLVER, GENERATE), tracks the menu cursor, and sends start pulses to the solver and maze-generator engines.
- Owns the busy/done handshake with those engines.

Parameters:
- DEBOUNCE_CYCLES, 650000, cycles a synchronized input must differ from its debounced value before the debounced value takes it (10 ms at 65 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_in  input  1  system pixel clock.
- reset_in  input  1  asynchronous, active-high reset.
- btnc  input  1  raw select button, asynchronous.
- btnu  input  1  raw cursor-up button.
- btnd  input  1  raw cursor-down button.
- btnl  input  1  raw back button.
- solve_done  input  1  one-cycle pulse from the solver engine.
- gen_done  input  1  one-cycle pulse from the generator engine.
- state  output  4  menu state code: 0 IDLE, 1 MANUAL, 2 SOLVER, 3 GENERATE.
- cursor  output  2  highlighted menu item, 0..2.
- busy  output  1  high while an engine started by this block is running.
- solve_start  output  1  one-cycle start pulse to the solver.
- gen_start  output  1  one-cycle start pulse to the generator.

Behaviour:
- Reset values: state=0, cursor=0, busy=0, solve_start=0, gen_start=0. All synchronizers, debounced values, counters and edge registers are cleared to 0.
- Reset asserted mid-debounce or mid-run aborts everything; the engines see no further start pulses.
- Per-button input path:
  - 2-flop synchronizer.
  - Counter increments each cycle while the synchronized value differs from the debounced value, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is filtered out.
- Press pulse = debounced & ~debounced_q (registered previous value). It is high for exactly one cycle per debounced rising edge; a held button produces exactly one pulse.
- State register updates on the cycle after the press pulse. Total latency from raw edge to state change = 2 (sync) + DEBOUNCE_CYCLES + 2 cycles.
- IDLE:
  - Up press: cursor = (cursor==0) ? 2 : cursor-1.
  - Down press: cursor = (cursor==2) ? 0 : cursor+1.
  - Select press: cursor 0 -> MANUAL; cursor 1 -> SOLVER, solve_start=1 for one cycle, busy=1; cursor 2 -> GENERATE, gen_start=1 for one cycle, busy=1.
  - Start pulses and busy are registered in the same clock edge as the state change.
- MANUAL: back press -> IDLE. Cursor is held.
- SOLVER / GENERATE:
  - The matching done pulse clears busy; the state does not change.
  - Back press while busy=0 -> IDLE.
  - Back press while busy=1 is ignored and not queued.
  - A done pulse and a back press in the same cycle: busy clears on this edge; back is ignored; a later back press returns to IDLE.
  - The non-matching done pulse (e.g. gen_done in SOLVER) is ignored.
- Done pulses are ignored in IDLE and MANUAL, and whenever busy=0.
- Simultaneous press pulses in one cycle, priority: back > select > up > down. Only the highest-priority press that is legal in the current state acts; the others are dropped.
- Up/down/select are ignored outside IDLE.
- state codes 4..15 are never produced. If the state register is found outside 0..3, it returns to IDLE on the next edge.

Decomposition:
- Package ui_pkg holds:
  - state encodings ST_IDLE=4'd0, ST_MANUAL=4'd1, ST_SOLVER=4'd2, ST_GENERATE=4'd3, shared with the renderer;
  - menu item constants MENU_MANUAL=2'd0, MENU_SOLVER=2'd1, MENU_GENERATE=2'd2.
- One sub-module, button_debounce: synchronizer, counter and press-pulse output.
  - Parameterized by DEBOUNCE_CYCLES.
  - Instantiated four times (btnc, btnu, btnd, btnl).
  - The FSM stays in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset and stimuli:
  - Assert reset_in mid-clock with all buttons high -> state=0, cursor=0, busy=0, no start pulses while reset is held.
  - Release reset with buttons low -> outputs stay at 0.
- Pulse btnd high for 3 cycles, then hold it 20 cycles -> the 3-cycle glitch leaves cursor at 0; the held press moves cursor to 1 exactly once, 8 cycles after the raw edge.
- From cursor=0, up press -> cursor=2 (wrap); then down press -> cursor=0 (wrap).
- Cursor=1, select press -> state=2, busy=1, solve_start high exactly 1 cycle.
  - Back press during busy -> state stays 2.
  - solve_done pulse -> busy=0.
  - Back press -> state=0.
- Cursor=2, select -> state=3, gen_start 1 cycle.
  - gen_done and a back press pulse land in the same cycle -> busy=0, state stays 3.
  - Next back press -> state=0.
  - solve_done injected in IDLE -> no change.
- Cursor=0, select and back pressed simultaneously in IDLE -> back wins but is illegal in IDLE, so nothing changes: state=0, cursor=0.
  - Select alone -> state=1, no start pulses.
  - Reset asserted while in state 1 -> state=0 immediately (asynchronously).
